viterbi_seq_ctrl: RTL
=====================

Name: viterbi_seq_ctrl

Overview:
Sequencer for the Viterbi decoder datapath. It accepts one received symbol per handshake and steps the add-compare-select (ACS) unit through every trellis state. It then commits the survivor column, runs traceback over the survivor memory once the window is full, and emits one decoded bit per traceback. It is the only block that drives the ACS enables and the 6-bit column counters.

Parameters:
NUM_STATES, 4, trellis states (power of 2, 2..64); SW = clog2(NUM_STATES)
TB_DEPTH, 32, traceback window in columns (2..64)
CW, 6, column counter width; must satisfy 2^CW >= TB_DEPTH

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  symbol available
in_ready  out  1  controller can accept a symbol
flush  in  1  sampled with an accepted symbol; marks it as the last symbol
acs_en  out  1  ACS processes state acs_idx this cycle
acs_idx  out  SW  state index under ACS
acs_first  out  1  first ACS cycle of a symbol (datapath latches symbol)
sv_we  out  1  write survivor column wr_col
pm_swap  out  1  swap path-metric banks
wr_col  out  CW  survivor write column
tb_en  out  1  traceback step active
tb_start  out  1  first traceback cycle (datapath loads best state)
tb_col  out  CW  survivor read column
tb_bit  in  1  decision bit from survivor memory for current tb_col
out_valid  out  1  decoded bit valid
out_bit  out  1  decoded bit
out_ready  in  1  consumer accepts bit
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. acs_idx, wr_col, tb_col, fill, tb_cnt and the flush latch = 0. All strobes = 0; out_valid = 0, out_bit = 0. Reset mid-operation abandons the symbol with no output.
- States: IDLE, ACS, COMMIT, TB, OUT. in_ready = 1 only in IDLE.
- IDLE: in_valid=1 -> ACS. Latch flush, acs_idx=0.
- ACS: acs_en=1 for exactly NUM_STATES cycles, acs_idx 0..NUM_STATES-1. acs_first=1 on the idx-0 cycle only. Then COMMIT.
- COMMIT (1 cycle): sv_we=1 and pm_swap=1. Then wr_col <= (wr_col+1) mod TB_DEPTH (TB_DEPTH-1 wraps to 0) and fill <= fill+1.
  - If new fill==TB_DEPTH, or the flush latch is set and new fill>0 -> TB.
  - Otherwise -> IDLE.
- TB: lasts fill cycles.
  - First cycle: tb_start=1, tb_col = wr_col-1 mod TB_DEPTH (newest column).
  - Each later cycle: tb_col decrements mod TB_DEPTH (0 wraps to TB_DEPTH-1).
  - On the last cycle (tb_col = oldest column = wr_col-fill mod TB_DEPTH): out_bit <= tb_bit, out_valid <= 1, fill <= fill-1. Then OUT.
- OUT: out_valid and out_bit held stable until out_ready=1. On the handshake cycle out_valid drops the next cycle.
  - If the flush latch is set and fill>0 -> TB again.
  - If the flush latch is set and fill==0 -> clear flush latch, -> IDLE.
  - Otherwise -> IDLE.
- Steady state: fill oscillates between TB_DEPTH-1 and TB_DEPTH. Exactly one bit is output per symbol after the first TB_DEPTH-1 symbols.
- Per-symbol latency: acceptance at cycle 0, ACS at cycles 1..NUM_STATES, COMMIT at cycle NUM_STATES+1.
  - Traceback adds fill cycles. out_valid rises the cycle after the last TB cycle.
- flush with fill=0 after commit is impossible, because commit always increments fill.
- Outputs are registered except in_ready, busy, acs_en, sv_we, tb_en. These five are decoded from the state register.

Decomposition:
- Package viterbi_pkg: state enum (IDLE, ACS, COMMIT, TB, OUT), CW default, and helper function for modular decrement of a column index.
- One natural sub-module: viterbi_col_ctr, a CW-bit mod-TB_DEPTH up/down counter with enable and load, reused for wr_col and tb_col.

Test Plan:
1. Reset with reset=0 mid-ACS (acs_idx=2) -> next edge state IDLE. acs_idx=0, wr_col=0, all strobes 0, in_ready=1.
2. NUM_STATES=4: one symbol at cycle 0 -> acs_en cycles 1-4 with idx 0,1,2,3. acs_first only at cycle 1. sv_we and pm_swap at cycle 5. wr_col=1 and in_ready=1 at cycle 6.
3. TB_DEPTH=4: four symbols (no flush) -> after the 4th commit, TB for 4 cycles with tb_col 3,2,1,0. tb_start on the first cycle. out_valid with out_bit=tb_bit sampled at tb_col=0.
4. Continue to symbol 9 -> wr_col wraps 3->0. Traceback reads 0,3,2,1, proving decrement wrap. One out_valid per symbol.
5. out_ready held 0 for 5 cycles -> out_valid and out_bit stable, in_ready=0. Output releases on out_ready=1.
6. TB_DEPTH=4, three symbols, flush on the 3rd -> three tracebacks of length 3, 2, 1. Three outputs, then IDLE with fill=0 and flush latch cleared.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi decoder sequencer.
package viterbi_pkg;

  localparam int unsigned CW_DEFAULT = 6;

  typedef enum logic [2:0] {
    StIdle,
    StAcs,
    StCommit,
    StTb,
    StOut
  } state_e;

  // Step a column index back by one inside a window of 'depth' columns.
  function automatic int unsigned col_dec(input int unsigned col, input int unsigned depth);
    return (col == 0) ? depth - 1 : col - 1;
  endfunction

endpackage

// File: rtl/viterbi_col_ctr.sv
// Modulo-TB_DEPTH up/down column counter with synchronous load.
module viterbi_col_ctr
  import viterbi_pkg::*;
#(
  parameter int unsigned CW       = CW_DEFAULT,
  parameter int unsigned TB_DEPTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          up,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] col
);

  localparam logic [CW-1:0] LastCol = CW'(TB_DEPTH - 1);

  logic [CW-1:0] col_d;

  // Load wins over count; counting wraps at both ends of the window.
  always_comb begin
    col_d = col;
    if (load) begin
      col_d = load_val;
    end else if (en) begin
      if (up) begin
        col_d = (col == LastCol) ? '0 : col + 1'b1;
      end else begin
        col_d = CW'(col_dec(32'(col), TB_DEPTH));
      end
    end
  end

  // Column register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
    end else begin
      col <= col_d;
    end
  end

endmodule

// File: rtl/viterbi_seq_ctrl.sv
// Viterbi sequencer: per-symbol ACS sweep, survivor commit, traceback and bit output.
module viterbi_seq_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned NUM_STATES = 4,
  parameter int unsigned TB_DEPTH   = 32,
  parameter int unsigned CW         = CW_DEFAULT,
  localparam int unsigned SW        = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          acs_en,
  output logic [SW-1:0] acs_idx,
  output logic          acs_first,
  output logic          sv_we,
  output logic          pm_swap,
  output logic [CW-1:0] wr_col,
  output logic          tb_en,
  output logic          tb_start,
  output logic [CW-1:0] tb_col,
  input  logic          tb_bit,
  output logic          out_valid,
  output logic          out_bit,
  input  logic          out_ready,
  output logic          busy
);

  // fill counts 0..TB_DEPTH inclusive, so it needs one more code than a column.
  localparam int unsigned FW = $clog2(TB_DEPTH + 1);

  state_e        state;
  logic [FW-1:0] fill;
  logic [FW-1:0] tb_cnt;
  logic          flush_lat;

  logic [FW-1:0] fill_inc;
  logic          commit_to_tb;
  logic          out_to_tb;
  logic          tb_last;
  logic          tb_load;
  logic          tb_dec;
  logic [CW-1:0] tb_load_val;

  assign in_ready = (state == StIdle);
  assign busy     = (state != StIdle);
  assign acs_en   = (state == StAcs);
  assign sv_we    = (state == StCommit);
  assign tb_en    = (state == StTb);

  // Transition conditions and traceback column control.
  always_comb begin
    fill_inc     = fill + 1'b1;
    commit_to_tb = (fill_inc == FW'(TB_DEPTH)) || (flush_lat && (fill_inc != '0));
    out_to_tb    = (state == StOut) && out_ready && flush_lat && (fill != '0);
    tb_last      = (tb_cnt == '0);
    tb_load      = ((state == StCommit) && commit_to_tb) || out_to_tb;
    tb_dec       = (state == StTb) && !tb_last;
    // From COMMIT wr_col advances on the same edge, so its current value is already newest.
    tb_load_val  = (state == StCommit) ? wr_col : CW'(col_dec(32'(wr_col), TB_DEPTH));
  end

  viterbi_col_ctr #(
    .CW       (CW),
    .TB_DEPTH (TB_DEPTH)
  ) u_wr_ctr (
    .clk      (clk),
    .reset    (reset),
    .en       (sv_we),
    .up       (1'b1),
    .load     (1'b0),
    .load_val ({CW{1'b0}}),
    .col      (wr_col)
  );

  viterbi_col_ctr #(
    .CW       (CW),
    .TB_DEPTH (TB_DEPTH)
  ) u_tb_ctr (
    .clk      (clk),
    .reset    (reset),
    .en       (tb_dec),
    .up       (1'b0),
    .load     (tb_load),
    .load_val (tb_load_val),
    .col      (tb_col)
  );

  // Main sequencer FSM with registered strobes and output bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      acs_idx   <= '0;
      acs_first <= 1'b0;
      pm_swap   <= 1'b0;
      tb_start  <= 1'b0;
      fill      <= '0;
      tb_cnt    <= '0;
      flush_lat <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else begin
      acs_first <= 1'b0;
      pm_swap   <= 1'b0;
      tb_start  <= 1'b0;
      case (state)
        StIdle: begin
          if (in_valid) begin
            state     <= StAcs;
            flush_lat <= flush;
            acs_idx   <= '0;
            acs_first <= 1'b1;
          end
        end
        StAcs: begin
          // NUM_STATES is a power of two, so the index wraps back to 0 on exit.
          acs_idx <= acs_idx + 1'b1;
          if (acs_idx == SW'(NUM_STATES - 1)) begin
            state   <= StCommit;
            pm_swap <= 1'b1;
          end
        end
        StCommit: begin
          fill <= fill_inc;
          if (commit_to_tb) begin
            state    <= StTb;
            tb_start <= 1'b1;
            tb_cnt   <= fill_inc - 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        StTb: begin
          if (tb_last) begin
            out_bit   <= tb_bit;
            out_valid <= 1'b1;
            fill      <= fill - 1'b1;
            state     <= StOut;
          end else begin
            tb_cnt <= tb_cnt - 1'b1;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_to_tb) begin
              state    <= StTb;
              tb_start <= 1'b1;
              tb_cnt   <= fill - 1'b1;
            end else begin
              flush_lat <= 1'b0;
              state     <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
